// File: rtl/fir_mac_engine.sv
// Streaming 11-tap FIR core: accepts one sample into a circular history in data BRAM,
// runs an 11-cycle multiply-accumulate against the tap BRAM, then emits one output sample.
module fir_mac_engine #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                          axis_clk,
  input  logic                          axis_rst_n,
  input  logic                          ap_start,
  input  logic [pDATA_WIDTH-1:0]        data_length,
  output logic                          ap_idle,
  output logic                          ap_done,
  input  logic                          ss_tvalid,
  input  logic signed [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                          ss_tlast,
  output logic                          ss_tready,
  input  logic                          sm_tready,
  output logic                          sm_tvalid,
  output logic signed [pDATA_WIDTH-1:0] sm_tdata,
  output logic                          sm_tlast,
  output logic                          tap_EN,
  output logic [pADDR_WIDTH-1:0]        tap_A,
  input  logic signed [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]                    data_WE,
  output logic                          data_EN,
  output logic [pDATA_WIDTH-1:0]        data_Di,
  output logic [pADDR_WIDTH-1:0]        data_A,
  input  logic signed [pDATA_WIDTH-1:0] data_Do
);

  localparam int IDX_W = $clog2(Tape_Num + 1);
  localparam logic [IDX_W-1:0] TAPS_I = IDX_W'(Tape_Num);
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(Tape_Num - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               head_q, head_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [pDATA_WIDTH-1:0]         count_q, count_d;
  logic [pDATA_WIDTH-1:0]         len_q, len_d;
  logic signed [pDATA_WIDTH-1:0]  acc_q, acc_d;
  logic                           vld_p0;
  logic                           vld_p1_q;
  logic [IDX_W-1:0]               rd_idx;

  // Termination is by count alone, so the stream's last flag carries no meaning here.
  wire unused_tlast = ss_tlast;

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] i);
    return pADDR_WIDTH'({i, 2'b00});
  endfunction

  // Full signed product, but only the low word survives; the accumulator wraps modulo 2^W.
  function automatic logic signed [pDATA_WIDTH-1:0] mac_wrap(
    input logic signed [pDATA_WIDTH-1:0] acc,
    input logic signed [pDATA_WIDTH-1:0] a,
    input logic signed [pDATA_WIDTH-1:0] b
  );
    logic signed [2*pDATA_WIDTH-1:0] prod;
    prod = $signed({{pDATA_WIDTH{a[pDATA_WIDTH-1]}}, a}) *
           $signed({{pDATA_WIDTH{b[pDATA_WIDTH-1]}}, b});
    return acc + $signed(prod[pDATA_WIDTH-1:0]);
  endfunction

  // History slot i samples back from head, wrapping modulo Tape_Num.
  always_comb begin
    rd_idx = (head_q >= idx_q) ? (head_q - idx_q) : (head_q + TAPS_I - idx_q);
  end

  assign vld_p0 = (state_q == S_MAC) && (idx_q != TAPS_I);

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    idx_d     = idx_q;
    count_d   = count_q;
    len_d     = len_q;
    acc_d     = acc_q;
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tdata  = '0;
    sm_tlast  = 1'b0;
    tap_EN    = 1'b0;
    tap_A     = '0;
    data_EN   = 1'b0;
    data_WE   = 4'h0;
    data_Di   = '0;
    data_A    = '0;

    if (vld_p1_q) begin
      acc_d = mac_wrap(acc_q, tap_Do, data_Do);
    end

    unique case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          len_d   = data_length;
          head_d  = '0;
          count_d = '0;
          idx_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = word_addr(idx_q);
        if (idx_q == LAST_I) begin
          idx_d   = '0;
          state_d = (len_q == '0) ? S_DONE : S_WAIT_IN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          data_A  = word_addr(head_q);
          data_Di = ss_tdata;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      // Reads issue on cycles 0..10; products land one cycle later via vld_p1_q.
      S_MAC: begin
        if (idx_q != TAPS_I) begin
          tap_EN  = 1'b1;
          tap_A   = word_addr(idx_q);
          data_EN = 1'b1;
          data_A  = word_addr(rd_idx);
          idx_d   = idx_q + 1'b1;
        end else begin
          idx_d   = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tdata  = acc_q;
        sm_tlast  = (count_q == len_q - 1);
        if (sm_tready) begin
          head_d  = (head_q == LAST_I) ? '0 : head_q + 1'b1;
          count_d = count_q + 1;
          state_d = (count_q + 1 == len_q) ? S_DONE : S_WAIT_IN;
        end
      end
      S_DONE: begin
        ap_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q  <= S_IDLE;
      head_q   <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      vld_p1_q <= vld_p0;
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine: BRAM models, a history-queue FIR reference, directed + random runs.
module tb_fir_mac_engine;
  localparam int NT = 11;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ap_start;
  logic [31:0]        data_length;
  logic               ap_idle, ap_done;
  logic               ss_tvalid, ss_tlast, ss_tready;
  logic signed [31:0] ss_tdata;
  logic               sm_tready, sm_tvalid, sm_tlast;
  logic signed [31:0] sm_tdata;
  logic               tap_EN, data_EN;
  logic [11:0]        tap_A, data_A;
  logic signed [31:0] tap_Do, data_Do;
  logic [3:0]         data_WE;
  logic [31:0]        data_Di;

  int tap_mem [16];
  int data_mem [16];
  int ins_q [$];
  int exp_q [$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rdy_cnt = 0, done_cnt = 0;

  always #5 clk = ~clk;

  fir_mac_engine dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .ap_start(ap_start), .data_length(data_length),
    .ap_idle(ap_idle), .ap_done(ap_done), .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata),
    .ss_tlast(ss_tlast), .ss_tready(ss_tready), .sm_tready(sm_tready), .sm_tvalid(sm_tvalid),
    .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .tap_EN(tap_EN), .tap_A(tap_A), .tap_Do(tap_Do),
    .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do)
  );

  // Synchronous-read BRAMs, one cycle of latency.
  always @(posedge clk) if (tap_EN) tap_Do <= tap_mem[tap_A[5:2]];

  always @(posedge clk) begin
    if (data_EN) begin
      data_Do <= data_mem[data_A[5:2]];
      for (int b = 0; b < 4; b++)
        if (data_WE[b]) data_mem[data_A[5:2]][8*b +: 8] <= data_Di[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (data_EN && data_WE == 4'hF) wr_cnt <= wr_cnt + 1;
    if (ss_tready) rdy_cnt <= rdy_cnt + 1;
    if (ap_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ap_idle"}, 32'(ap_idle), 32'd1);
    chk({tag, "_ap_done"}, 32'(ap_done), 32'd0);
    chk({tag, "_ss_tready"}, 32'(ss_tready), 32'd0);
    chk({tag, "_sm_tvalid"}, 32'(sm_tvalid), 32'd0);
    chk({tag, "_sm_tdata"}, sm_tdata, 32'd0);
    chk({tag, "_sm_tlast"}, 32'(sm_tlast), 32'd0);
    chk({tag, "_tap_EN"}, 32'(tap_EN), 32'd0);
    chk({tag, "_data_EN"}, 32'(data_EN), 32'd0);
    chk({tag, "_data_WE"}, 32'(data_WE), 32'd0);
  endtask

  // Reference: newest sample at hist[0]; y = sum tap[i]*hist[i], modulo 2^32.
  task automatic model();
    int hist [NT];
    int y;
    for (int i = 0; i < NT; i++) hist[i] = 0;
    exp_q.delete();
    foreach (ins_q[k]) begin
      for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ins_q[k];
      y = 0;
      for (int i = 0; i < NT; i++) y += tap_mem[i] * hist[i];
      exp_q.push_back(y);
    end
  endtask

  task automatic run(input string name, input int stall_at, input int stall_len);
    int len;
    int n;
    int wr0, rdy0;
    len = ins_q.size();
    model();
    wr0 = wr_cnt;
    rdy0 = rdy_cnt;
    data_length = 32'(len);
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    for (int k = 0; k < len; k++) begin
      ss_tdata  = ins_q[k];
      ss_tlast  = (k == len - 1);
      ss_tvalid = 1'b1;
      n = 0;
      while (!ss_tready && n < 200) begin @(posedge clk); #1; n++; end
      chk({name, "_ss_tready_wait"}, 32'(ss_tready), 32'd1);
      if (!ss_tready) begin ss_tvalid = 1'b0; return; end
      @(posedge clk); #1;
      ss_tvalid = 1'b0;
      ss_tdata  = $urandom;
      chk({name, "_ss_tready_after_accept"}, 32'(ss_tready), 32'd0);
      n = 0;
      while (!sm_tvalid && n < 50) begin @(posedge clk); #1; n++; end
      chk({name, "_sm_tvalid_wait"}, 32'(sm_tvalid), 32'd1);
      if (!sm_tvalid) return;
      if (k == stall_at) begin
        repeat (stall_len) begin
          @(posedge clk); #1;
          chk({name, "_stall_data"}, sm_tdata, exp_q[k]);
          chk({name, "_stall_valid"}, 32'(sm_tvalid), 32'd1);
          chk({name, "_stall_ss_tready"}, 32'(ss_tready), 32'd0);
        end
      end
      chk($sformatf("%s_out%0d", name, k), sm_tdata, exp_q[k]);
      chk($sformatf("%s_tlast%0d", name, k), 32'(sm_tlast), 32'(k == len - 1));
      sm_tready = 1'b1;
      @(posedge clk); #1;
      sm_tready = 1'b0;
      chk({name, "_valid_drop"}, 32'(sm_tvalid), 32'd0);
      chk($sformatf("%s_ap_done%0d", name, k), 32'(ap_done), 32'(k == len - 1));
    end
    chk({name, "_clear_and_input_writes"}, 32'(wr_cnt - wr0), 32'(NT + len));
    chk({name, "_ready_cycles"}, 32'(rdy_cnt - rdy0), 32'(len));
    @(posedge clk); #1;
    chk({name, "_done_one_cycle"}, 32'(ap_done), 32'd0);
    chk({name, "_idle_after"}, 32'(ap_idle), 32'd1);
  endtask

  initial begin
    int n, wr0, rdy0, done0;
    rst_n = 1'b0; ap_start = 1'b0; data_length = '0;
    ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0; sm_tready = 1'b0;
    for (int i = 0; i < 16; i++) tap_mem[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse response
    tap_mem[0:10] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    ins_q = {1};
    repeat (10) ins_q.push_back(0);
    run("impulse", -1, 0);

    // Running sum, then a short run on a freshly cleared history
    for (int i = 0; i < NT; i++) tap_mem[i] = 1;
    ins_q = {1, 2, 3, 4, 5};
    run("runsum", -1, 0);
    ins_q = {7, 8};
    run("rerun", -1, 0);

    // Head wraps 10 -> 0
    ins_q.delete();
    repeat (14) ins_q.push_back(1);
    run("wrap", -1, 0);

    // Random taps/samples with a long output stall
    for (int i = 0; i < NT; i++) tap_mem[i] = $urandom;
    ins_q.delete();
    repeat (8) ins_q.push_back($urandom);
    run("backpressure", 3, 20);

    // len = 0: clear only, then done
    wr0 = wr_cnt; rdy0 = rdy_cnt;
    data_length = '0;
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    chk("len0_busy", 32'(ap_idle), 32'd0);
    n = 0;
    while (!ap_done && n < 30) begin @(posedge clk); #1; n++; end
    chk("len0_ap_done", 32'(ap_done), 32'd1);
    chk("len0_clear_writes", 32'(wr_cnt - wr0), 32'd11);
    chk("len0_no_ready", 32'(rdy_cnt - rdy0), 32'd0);
    @(posedge clk); #1;
    chk("len0_idle", 32'(ap_idle), 32'd1);
    chk("len0_done_low", 32'(ap_done), 32'd0);

    // Product and accumulator wrap
    for (int i = 0; i < NT; i++) tap_mem[i] = 32'h7FFF_FFFF;
    ins_q = {2, 3};
    run("wrap_arith", -1, 0);

    // Reset in the middle of a MAC
    for (int i = 0; i < NT; i++) tap_mem[i] = int'($urandom_range(0, 200)) - 100;
    data_length = 32'd3;
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    ss_tdata = 32'sd5; ss_tvalid = 1'b1;
    n = 0;
    while (!ss_tready && n < 50) begin @(posedge clk); #1; n++; end
    chk("rst_mid_ready", 32'(ss_tready), 32'd1);
    @(posedge clk); #1;
    ss_tvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_in_mac", 32'(tap_EN), 32'd1);
    done0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_mid_no_done", 32'(done_cnt - done0), 32'd0);
    chk("rst_mid_idle", 32'(ap_idle), 32'd1);

    // Fresh run after the abort must see a clean history
    ins_q.delete();
    repeat (6) ins_q.push_back(int'($urandom_range(0, 2000)) - 1000);
    run("after_reset", -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
- Datapath stage directly downstream of the FIR tap BRAM and the AXI-Lite config block.
- Consumes the AXI-Stream input samples and keeps the 11-sample history in the data BRAM as a circular buffer.
- For each input sample, performs one 11-tap multiply-accumulate using coefficients read from the tap BRAM, then emits one AXI-Stream output sample.
- Started by ap_start from the config block; reports ap_idle and ap_done back to it.

Parameters:
- pADDR_WIDTH, 12, BRAM byte-address width.
- pDATA_WIDTH, 32, sample, coefficient and accumulator width.
- Tape_Num, 11, number of taps and the history depth.

Ports:
- axis_clk  in  1  sole clock; all logic on the rising edge.
- axis_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  single-cycle start pulse; sampled only in IDLE.
- data_length  in  32  number of samples to process; latched on start.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse when the run completes.
- ss_tvalid  in  1  input stream valid.
- ss_tdata  in  32  input sample, signed.
- ss_tlast  in  1  input last; ignored for termination.
- ss_tready  out  1  input stream ready.
- sm_tready  in  1  output stream ready.
- sm_tvalid  out  1  output stream valid.
- sm_tdata  out  32  filtered sample, signed.
- sm_tlast  out  1  high with the data_length-th output.
- tap_EN  out  1  tap BRAM enable; read-only use.
- tap_A  out  12  tap byte address = i<<2.
- tap_Do  in  32  tap read data; valid one cycle after the address.
- data_WE  out  4  data BRAM byte write enables.
- data_EN  out  1  data BRAM enable.
- data_Di  out  32  data BRAM write data.
- data_A  out  12  data BRAM byte address = index<<2.
- data_Do  in  32  data BRAM read data; one-cycle latency.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, head=0, count=0, acc=0.
  - Outputs: ap_idle=1, ap_done=0, ss_tready=0, sm_tvalid=0, sm_tdata=0, sm_tlast=0, tap_EN=0, data_EN=0, data_WE=0.
- IDLE: on ap_start=1, latch data_length into len, head=0, count=0, go to CLEAR. ap_start in any other state is ignored.
- CLEAR (11 cycles): write zero to data indices 0..10 (data_WE=4'hF). Then go to DONE if len==0, else WAIT_IN.
- WAIT_IN: ss_tready=1.
  - On ss_tvalid&&ss_tready, write ss_tdata to data[head] and clear acc.
  - Deassert ss_tready the next cycle and go to MAC.
- MAC (12 cycles):
  - Cycles 0..10 issue tap_A=i<<2 and data index (head>=i ? head-i : head+11-i).
  - Cycles 1..11: acc = acc + tap_Do*data_Do.
  - The product is a signed 32x32 multiply; only the low 32 bits are kept, and the accumulator wraps modulo 2^32.
- OUT: sm_tvalid=1, sm_tdata=acc, sm_tlast=(count==len-1).
  - sm_tdata and sm_tlast stay stable until sm_tready=1.
  - On handshake: sm_tvalid drops next cycle, head=(head==10)?0:head+1, count=count+1.
  - Then go to DONE if count+1==len, else WAIT_IN.
- DONE: ap_done=1 for exactly one cycle, then IDLE, where ap_idle=1.
- ss_tready is never high outside WAIT_IN. One input is accepted per output, so there is no overlap between samples.
- head wraps 10->0. The history index wraps modulo 11.
- ss_tlast is not checked; count alone terminates the run.
- Reset mid-run aborts the run with no ap_done. A new run requires ap_start, and CLEAR re-zeroes the history.

Test Plan:
- Impulse response: taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, len=11, inputs 1,0,...,0.
  - Required: outputs 0,-10,-9,23,56,63,56,23,-9,-10,0.
  - sm_tlast only on the 11th output; ap_done pulse one cycle after that handshake.
- Running sum: all taps 1, len=5, inputs 1..5.
  - Required: outputs 1,3,6,10,15.
  - Second run with len=2, inputs 7,8: outputs 7,15, proving CLEAR erased the history.
- Wrap-around: all taps 1, len=14, inputs all 1.
  - Required: outputs 1,2,...,11,11,11,11, with head passing 10->0.
- Backpressure: hold sm_tready=0 for 20 cycles at output 3.
  - Required: sm_tdata stable, ss_tready=0 throughout, no sample lost, final results unchanged.
- len=0: ap_start pulse.
  - Required: 11 CLEAR writes, ss_tready never high, ap_done pulse, ap_idle back to 1.
- Arithmetic and reset:
  - Taps 0x7FFFFFFF, input 2: the low 32 bits wrap to 0xFFFFFFFE on output 1.
  - Reset asserted mid-MAC: all outputs return to reset values immediately, and no ap_done pulse occurs.
